frame_store: RTL
================

FRAME_STORE -- requirements
Module: frame_store

Interface
REQ-001 The block SHALL have the parameter W_DATA, default 16, meaning the data beat width in bits.
REQ-002 The block SHALL have the parameter ADDR_WIDTH, default 11, meaning the data RAM holds 2^ADDR_WIDTH beats and pointers are ADDR_WIDTH+1 bits wide.
REQ-003 The block SHALL have the parameter MAX_FRAMES, default 4, meaning the descriptor FIFO depth; it is a power of 2 and at least 2.
REQ-004 The block SHALL have the parameter ALMOST_FULL_THRESHOLD, default 10, meaning the free-beat count at or below which almost_full asserts.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 reset  in  1  synchronous, active-high
 in_tdata  in  W_DATA  ingress beat data
 in_tvalid  in  1  ingress beat present; there is no backpressure
 in_tlast  in  1  final beat of the ingress frame
 in_drop  in  1  abort the frame currently being written
 out_tdata  out  W_DATA  egress beat data
 out_tvalid  out  1  egress beat valid
 out_tlast  out  1  final beat of the egress frame
 out_tready  in  1  egress accepts the beat
 out_len  out  ADDR_WIDTH+1  beat count of the head committed frame; valid while out_tvalid=1
 frame_count  out  $clog2(MAX_FRAMES)+1  number of committed frames not yet fully read
 almost_full  out  1  registered low-space flag
 drop_count  out  16  frames dropped, saturating at 0xFFFF

Function
REQ-006 The write FSM SHALL have the states IDLE, WRITE and DISCARD; a beat is any cycle with in_tvalid=1.
REQ-007 In IDLE, when a beat arrives and either the descriptor FIFO is full or the data RAM is full, the block SHALL increment drop_count and go to DISCARD; if in_tlast=1 on that beat it SHALL stay in IDLE.
REQ-008 Otherwise, in IDLE a beat SHALL be written at wptr, wptr SHALL increment, frame_start SHALL latch the old wptr, and the FSM SHALL go to WRITE; if in_tlast=1 the frame SHALL commit instead.
REQ-009 In WRITE, a beat arriving while the RAM is full SHALL cause a rollback: wptr is set to frame_start, drop_count increments, and the FSM goes to DISCARD, or to IDLE if in_tlast=1.
REQ-010 In WRITE, or on a frame's first beat, in_drop=1 SHALL cause a rollback; the beat in that cycle is not written, and the FSM goes to DISCARD, or to IDLE if that beat carried in_tlast.
REQ-011 Commit SHALL happen on a written beat with in_tlast=1: the descriptor {frame_start, length} is pushed and the FSM returns to IDLE.
REQ-012 In DISCARD, beats SHALL be ignored, and the FSM SHALL return to IDLE after the beat carrying in_tlast.
REQ-013 A frame of exactly 2^ADDR_WIDTH beats SHALL fit when the RAM is empty at its start.
REQ-014 Full SHALL mean (wptr - rptr) == 2^ADDR_WIDTH, computed on registered pointers at cycle start, so a read in the same cycle does not free space for that cycle's write.
REQ-015 Pointer subtraction SHALL wrap modulo 2^(ADDR_WIDTH+1).
REQ-016 almost_full SHALL equal, one cycle late, the condition (2^ADDR_WIDTH - (wptr - rptr)) <= ALMOST_FULL_THRESHOLD.
REQ-017 The read side SHALL present only committed frames; out_tvalid SHALL rise no later than 2 cycles after the commit edge when the descriptor FIFO was empty.
REQ-018 With out_tready held at 1, the read side SHALL sustain 1 beat per cycle across frame boundaries, with no bubble between back-to-back committed frames.
REQ-019 While out_tvalid=1 and out_tready=0, out_tdata, out_tlast and out_len SHALL hold stable.
REQ-020 rptr SHALL advance on every accepted beat, freeing space immediately.
REQ-021 The descriptor SHALL pop on the accepted beat with out_tlast=1.
REQ-022 frame_count SHALL increment on commit and decrement on pop; a commit and a pop in the same cycle SHALL leave it unchanged.
REQ-023 A rollback SHALL never alter committed data, rptr, or the read-side state.

Reset
REQ-024 While reset=1, the FSM SHALL go to IDLE, and wptr, rptr, frame_start, the descriptor pointers, frame_count, drop_count, out_tvalid, out_tlast, out_len and almost_full SHALL all be 0.
REQ-025 A reset asserted mid-frame SHALL discard every stored and partial frame; the first beat after reset deasserts SHALL be treated as a frame start.

Verification (ADDR_WIDTH=4, MAX_FRAMES=2, ALMOST_FULL_THRESHOLD=2)
REQ-026 Scenario: 3-beat frame 0xA,0xB,0xC, out_tready=1 -> out_tdata A,B,C consecutively, out_tlast on C, out_len=3, frame_count 1 then 0.
REQ-027 Scenario: 18-beat frame into an empty store -> drop on beat 17, drop_count=1, out_tvalid stays 0, wptr returns to 0.
REQ-028 Scenario: in_drop on beat 2 of a 5-beat frame, then a 2-beat frame -> only the 2-beat frame is read, drop_count=1.
REQ-029 Scenario: three 2-beat frames with out_tready=0 -> third dropped, frame_count=2, drop_count=1; then raise out_tready -> 4 beats back-to-back.
REQ-030 Scenario: write 14 beats with out_tready=0 -> almost_full=1 one cycle after beat 14; read 1 beat -> almost_full=0 one cycle later.
REQ-031 Scenario: reset asserted during beat 3 of a frame -> all outputs 0 next cycle, and a following 1-beat frame is read correctly.

Source files
------------

// File: rtl/frame_store.sv
// frame_store: store-and-forward frame buffer. Ingress beats are written into a
// circular data RAM; a frame becomes visible on the egress side only once its
// last beat is written and its descriptor {start, length} is committed.
// Frames that do not fit, or are aborted with in_drop, are rolled back and counted.
module frame_store #(
  parameter int unsigned W_DATA                = 16,
  parameter int unsigned ADDR_WIDTH            = 11,
  parameter int unsigned MAX_FRAMES            = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [W_DATA-1:0]             in_tdata,
  input  logic                          in_tvalid,
  input  logic                          in_tlast,
  input  logic                          in_drop,
  output logic [W_DATA-1:0]             out_tdata,
  output logic                          out_tvalid,
  output logic                          out_tlast,
  input  logic                          out_tready,
  output logic [ADDR_WIDTH:0]           out_len,
  output logic [$clog2(MAX_FRAMES):0]   frame_count,
  output logic                          almost_full,
  output logic [15:0]                   drop_count
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DIW   = $clog2(MAX_FRAMES);
  localparam int unsigned DW    = DIW + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [PW-1:0] RAM_BEATS = PW'(DEPTH);
  localparam logic [DW-1:0] DESC_MAX  = DW'(MAX_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_DISCARD = 2'd2
  } wr_state_e;

  // Storage
  logic [W_DATA-1:0] mem        [DEPTH];
  logic [AW-1:0]     desc_start [MAX_FRAMES];
  logic [PW-1:0]     desc_len   [MAX_FRAMES];

  // Write side
  wr_state_e         state_q;
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     frame_start_q;
  logic [DW-1:0]     dwr_q;
  logic [15:0]       drop_count_q;
  logic              almost_full_q;

  // Read side
  logic [PW-1:0]     rptr_q;
  logic [DW-1:0]     drd_q;
  logic [DW-1:0]     dfetch_q;
  logic [AW-1:0]     fcnt_q;
  logic [DW-1:0]     frame_count_q;
  logic              out_tvalid_q;
  logic              out_tlast_q;
  logic [W_DATA-1:0] out_tdata_q;
  logic [PW-1:0]     out_len_q;

  // Occupancy and admission decisions, all from registered pointers
  logic [PW-1:0] used_c;
  logic [PW-1:0] free_c;
  logic          ram_full_c;
  logic          desc_full_c;
  logic          first_ok_c;
  logic          wr_en_c;
  logic          commit_c;
  logic          rollback_c;
  logic [PW-1:0] commit_start_c;
  logic [PW-1:0] commit_len_c;

  // Egress fetch and handshake
  logic [DIW-1:0] fidx_c;
  logic           avail_c;
  logic [AW-1:0]  fetch_addr_c;
  logic           fetch_last_c;
  logic           load_c;
  logic           accept_c;
  logic           pop_c;

  // Write-side admission: what happens to this cycle's ingress beat
  always_comb begin
    used_c         = wptr_q - rptr_q;
    free_c         = RAM_BEATS - used_c;
    ram_full_c     = (used_c == RAM_BEATS);
    desc_full_c    = ((dwr_q - drd_q) == DESC_MAX);
    first_ok_c     = !desc_full_c && !ram_full_c && !in_drop;
    wr_en_c        = in_tvalid &&
                     (((state_q == S_IDLE) && first_ok_c) ||
                      ((state_q == S_WRITE) && !ram_full_c && !in_drop));
    commit_c       = wr_en_c && in_tlast;
    rollback_c     = in_tvalid &&
                     (((state_q == S_IDLE) && !first_ok_c) ||
                      ((state_q == S_WRITE) && (ram_full_c || in_drop)));
    commit_start_c = (state_q == S_IDLE) ? wptr_q : frame_start_q;
    commit_len_c   = wptr_q + PW'(1) - commit_start_c;
  end

  // Read-side fetch: next beat to load from the committed frame queue
  always_comb begin
    fidx_c       = dfetch_q[DIW-1:0];
    avail_c      = (dfetch_q != dwr_q);
    fetch_addr_c = desc_start[fidx_c] + fcnt_q;
    fetch_last_c = (({1'b0, fcnt_q} + PW'(1)) == desc_len[fidx_c]);
    load_c       = !out_tvalid_q || out_tready;
    accept_c     = out_tvalid_q && out_tready;
    pop_c        = accept_c && out_tlast_q;
  end

  // Data RAM and descriptor storage writes (contents need no reset)
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wptr_q[AW-1:0]] <= in_tdata;
    end
    if (commit_c) begin
      desc_start[dwr_q[DIW-1:0]] <= commit_start_c[AW-1:0];
      desc_len[dwr_q[DIW-1:0]]   <= commit_len_c;
    end
  end

  // Write FSM: frame admission, rollback, commit and drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wptr_q        <= '0;
      frame_start_q <= '0;
      dwr_q         <= '0;
      drop_count_q  <= '0;
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (32'(free_c) <= ALMOST_FULL_THRESHOLD);
      if (wr_en_c) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (commit_c) begin
        dwr_q <= dwr_q + DW'(1);
      end
      if (rollback_c && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
      if (in_tvalid) begin
        case (state_q)
          S_IDLE: begin
            if (first_ok_c) begin
              frame_start_q <= wptr_q;
              if (!in_tlast) begin
                state_q <= S_WRITE;
              end
            end else if (!in_tlast) begin
              state_q <= S_DISCARD;
            end
          end
          S_WRITE: begin
            if (rollback_c) begin
              wptr_q  <= frame_start_q;
              state_q <= in_tlast ? S_IDLE : S_DISCARD;
            end else if (in_tlast) begin
              state_q <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (in_tlast) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Egress pipeline: one-beat output register refilled whenever it drains
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q        <= '0;
      drd_q         <= '0;
      dfetch_q      <= '0;
      fcnt_q        <= '0;
      frame_count_q <= '0;
      out_tvalid_q  <= 1'b0;
      out_tlast_q   <= 1'b0;
      out_tdata_q   <= '0;
      out_len_q     <= '0;
    end else begin
      if (accept_c) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (pop_c) begin
        drd_q <= drd_q + DW'(1);
      end
      case ({commit_c, pop_c})
        2'b10:   frame_count_q <= frame_count_q + DW'(1);
        2'b01:   frame_count_q <= frame_count_q - DW'(1);
        default: frame_count_q <= frame_count_q;
      endcase
      if (load_c) begin
        out_tvalid_q <= avail_c;
        if (avail_c) begin
          out_tdata_q <= mem[fetch_addr_c];
          out_tlast_q <= fetch_last_c;
          out_len_q   <= desc_len[fidx_c];
          if (fetch_last_c) begin
            dfetch_q <= dfetch_q + DW'(1);
            fcnt_q   <= '0;
          end else begin
            fcnt_q <= fcnt_q + AW'(1);
          end
        end else begin
          out_tlast_q <= 1'b0;
        end
      end
    end
  end

  assign out_tdata   = out_tdata_q;
  assign out_tvalid  = out_tvalid_q;
  assign out_tlast   = out_tlast_q;
  assign out_len     = out_len_q;
  assign frame_count = frame_count_q;
  assign almost_full = almost_full_q;
  assign drop_count  = drop_count_q;

endmodule
